// File: rtl/nibble_demux_latch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_demux_latch: assembles low/high nibbles from a muxed bus into a   |
// | byte with valid/ready delivery and a delivered-byte counter.             |
// | Optional: NIBBLE_DEMUX_ERR_EN adds the err protocol-error pulse port.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nibble_demux_latch (
  input  logic       clk,
  input  logic       rst,
  input  logic       S,
  input  logic       nE,
  input  logic [3:0] y,
  output logic       bus_rdy,
  output logic [7:0] q,
  output logic       q_valid,
  input  logic       q_ready,
  output logic [7:0] cnt
`ifdef NIBBLE_DEMUX_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HAVE_LO = 1'b1
  } state_t;

  state_t     state_q;
  logic [3:0] lo_q;
  logic [7:0] byte_q;
  logic       q_valid_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       err_q;

  logic       w_bus_rdy;
  logic       w_accept;
  logic       w_deliver;
  logic       w_complete;
  logic       w_proto_err;

  // Stall the bus only when a finished byte is waiting and another is about
  // to complete; a low nibble can always be parked while q is blocked.
  assign w_bus_rdy   = !((state_q == HAVE_LO) && q_valid_q && !q_ready);
  assign w_accept    = !nE && w_bus_rdy;
  assign w_deliver   = q_valid_q && q_ready;
  assign w_complete  = w_accept && (state_q == HAVE_LO) && S;
  assign w_proto_err = w_accept && (((state_q == IDLE) && S) ||
                                    ((state_q == HAVE_LO) && !S));
  assign cnt_d       = w_deliver ? cnt_q + 8'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lo_q      <= 4'h0;
      byte_q    <= 8'h00;
      q_valid_q <= 1'b0;
      cnt_q     <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= w_proto_err;

      if (w_complete) begin
        byte_q    <= {y, lo_q};
        q_valid_q <= 1'b1;
      end else if (w_deliver) begin
        q_valid_q <= 1'b0;
      end

      if (w_accept) begin
        case (state_q)
          IDLE: begin
            if (!S) begin
              lo_q    <= y;
              state_q <= HAVE_LO;
            end
          end
          HAVE_LO: begin
            if (S) begin
              state_q <= IDLE;
            end else begin
              lo_q <= y;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus_rdy = w_bus_rdy;
  assign q       = byte_q;
  assign q_valid = q_valid_q;
  assign cnt     = cnt_q;

`ifdef NIBBLE_DEMUX_ERR_EN
  assign err = err_q;
`else
  logic w_unused_err;
  assign w_unused_err = err_q;
`endif

endmodule
`default_nettype wire
